// File: rtl/phys_reg_free_list_pkg.sv
// Shared types and constants for the physical register free list.
// Optional double-free bitmap: define PHYS_REG_FREE_LIST_DOUBLE_FREE_CHECK_EN.
package phys_reg_free_list_pkg;

  localparam int unsigned NUM_PHYREG  = 128;
  localparam int unsigned NUM_ARCHREG = 32;
  localparam int unsigned FREE_DEPTH  = NUM_PHYREG - NUM_ARCHREG;

  localparam int unsigned PhyIdW = $clog2(NUM_PHYREG);
  localparam int unsigned PtrW   = $clog2(FREE_DEPTH);
  localparam int unsigned CntW   = $clog2(FREE_DEPTH + 1);

  typedef logic [PhyIdW-1:0] PhyRegisterId_T;
  typedef logic [PtrW-1:0]   FreePtr_T;
  typedef logic [CntW-1:0]   FreeCnt_T;

  typedef enum logic [0:0] {INIT, ACTIVE} FreeListState_T;

  localparam FreePtr_T LastPtr = FreePtr_T'(FREE_DEPTH - 1);
  localparam FreeCnt_T FullCnt = FreeCnt_T'(FREE_DEPTH);

  // Depth is not a power of two, so wrap explicitly.
  function automatic FreePtr_T ptr_inc(input FreePtr_T p);
    return (p == LastPtr) ? '0 : p + FreePtr_T'(1);
  endfunction

endpackage

// File: rtl/phys_reg_free_list_storage.sv
// Free-list entry array: one synchronous write port, one asynchronous read port.
module phys_reg_free_list_storage
  import phys_reg_free_list_pkg::*;
(
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [PtrW-1:0]   waddr_i,
  input  logic [PhyIdW-1:0] wdata_i,
  input  logic [PtrW-1:0]   raddr_i,
  output logic [PhyIdW-1:0] rdata_o
);

  PhyRegisterId_T mem_q [FREE_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register IDs with self-sequenced initialisation.
// Define PHYS_REG_FREE_LIST_DOUBLE_FREE_CHECK_EN to add the in-list double-free bitmap.
module phys_reg_free_list
  import phys_reg_free_list_pkg::*;
(
  input  logic              SIG_CLK,
  input  logic              SIG_RSTn,
  input  logic              allocReq,
  output logic              allocGrant,
  output logic [PhyIdW-1:0] allocPhyReg,
  input  logic              releaseValid,
  input  logic [PhyIdW-1:0] releasePhyReg,
  output logic [CntW-1:0]   freeCount,
  output logic              listReady,
  output logic              doubleFreeErr
);

  FreeListState_T state_q, state_d;
  FreePtr_T       head_q, head_d;
  FreePtr_T       tail_q, tail_d;
  FreePtr_T       index_q, index_d;
  FreeCnt_T       count_q, count_d;
  logic           err_q, err_d;

  logic           wr_en;
  FreePtr_T       wr_addr;
  PhyRegisterId_T wr_data;
  PhyRegisterId_T rd_data;

  logic grant;
  logic rel_ok;
  logic rel_accept;
  logic dup;

  phys_reg_free_list_storage u_storage (
    .clk_i   (SIG_CLK),
    .we_i    (wr_en),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .raddr_i (head_q),
    .rdata_o (rd_data)
  );

  assign grant      = (state_q == ACTIVE) && allocReq && (count_q != '0);
  assign rel_ok     = (state_q == ACTIVE) && releaseValid && (releasePhyReg != '0);
  // Occupancy test uses the pre-allocation count of this cycle.
  assign rel_accept = rel_ok && (count_q != FullCnt) && !dup;

`ifdef PHYS_REG_FREE_LIST_DOUBLE_FREE_CHECK_EN
  logic [NUM_PHYREG-1:0] in_list_q, in_list_d;

  assign dup = in_list_q[releasePhyReg];

  always_comb begin
    in_list_d = in_list_q;
    if (state_q == INIT) begin
      in_list_d[wr_data] = 1'b1;
    end else begin
      if (grant) in_list_d[rd_data] = 1'b0;
      if (rel_accept) in_list_d[releasePhyReg] = 1'b1;
    end
  end

  always_ff @(posedge SIG_CLK) begin
    if (!SIG_RSTn) begin
      in_list_q <= '0;
    end else begin
      in_list_q <= in_list_d;
    end
  end
`else
  assign dup = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    index_d = index_q;
    count_d = count_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    wr_addr = tail_q;
    wr_data = releasePhyReg;

    case (state_q)
      INIT: begin
        wr_en   = 1'b1;
        wr_addr = index_q;
        wr_data = PhyRegisterId_T'(NUM_ARCHREG) + PhyRegisterId_T'(index_q);
        tail_d  = ptr_inc(tail_q);
        index_d = ptr_inc(index_q);
        count_d = count_q + FreeCnt_T'(1);
        if (index_q == LastPtr) state_d = ACTIVE;
      end
      ACTIVE: begin
        if (grant) head_d = ptr_inc(head_q);
        if (rel_accept) begin
          wr_en  = 1'b1;
          tail_d = ptr_inc(tail_q);
        end
        // A release that finds the list full can only be a duplicate.
        if (rel_ok && ((count_q == FullCnt) || dup)) err_d = 1'b1;
        if (grant && !rel_accept) begin
          count_d = count_q - FreeCnt_T'(1);
        end else if (!grant && rel_accept) begin
          count_d = count_q + FreeCnt_T'(1);
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge SIG_CLK) begin
    if (!SIG_RSTn) begin
      state_q <= INIT;
      head_q  <= '0;
      tail_q  <= '0;
      index_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      index_q <= index_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign allocGrant    = grant;
  assign allocPhyReg   = grant ? rd_data : '0;
  assign freeCount     = count_q;
  assign listReady     = (state_q == ACTIVE);
  assign doubleFreeErr = err_q;

endmodule
